// File: rtl/logic_vector_sequencer.sv
// logic_vector_sequencer
//
// Purpose: steps the {A,B,C} inputs of a 3-input/2-output combinational
// datapath through all eight combinations. Each vector is held for a
// programmable dwell time. Y1/Y2 are sampled at the end of each dwell and
// checked against expected truth tables. The block reports pass/fail, the
// error count and the first failing vector.
//
// Optional feature: define LOGIC_SEQ_GRAY_EN to sweep the vectors in Gray
// order (000,001,011,010,110,111,101,100) instead of binary order 000..111.
// Capture bits, comparisons and o_first_err are always indexed by the vector
// value, not by the step number.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin a sweep (accepted only in IDLE; wins over i_abort there)
//   i_abort      synchronous abort of a running sweep
//   i_dwell      cycles per vector, latched at start, 0 treated as 1
//   i_exp_y1/2   expected truth tables, bit i = expected output at {A,B,C}=i
//   o_abc        drives {A,B,C} of the datapath
//   i_y1/i_y2    datapath outputs
//   o_busy       high while vectors are being applied
//   o_done       one-cycle pulse at sweep completion
//   o_pass       last completed sweep had zero mismatches
//   o_err_cnt    mismatching vectors in the current/last sweep (0..8)
//   o_first_err  first mismatching vector value, valid when o_err_cnt != 0
//   o_cap_y1/2   captured truth tables, bit i = sampled output at {A,B,C}=i

module logic_vector_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [7:0]         i_exp_y1,
  input  logic [7:0]         i_exp_y2,
  output logic [2:0]         o_abc,
  input  logic               i_y1,
  input  logic               i_y2,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [3:0]         o_err_cnt,
  output logic [2:0]         o_first_err,
  output logic [7:0]         o_cap_y1,
  output logic [7:0]         o_cap_y2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [2:0]         r_step;
  logic [2:0]         r_abc;
  logic               r_pass;
  logic [3:0]         r_err_cnt;
  logic [2:0]         r_first_err;
  logic [7:0]         r_cap_y1;
  logic [7:0]         r_cap_y2;

  logic               w_accept;
  logic               w_sample;
  logic               w_count;
  logic               w_mismatch;
  logic [DWELL_W-1:0] w_dwell_eff;

  // Step number to vector value. Gray order makes only one input toggle
  // per step, which keeps glitches on the datapath inputs to a minimum.
  function automatic logic [2:0] step_to_abc(input logic [2:0] step);
`ifdef LOGIC_SEQ_GRAY_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

  // A dwell of 0 would never let the down-counter expire cleanly, so it is
  // promoted to 1.
  assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

  // The expected tables are read live, indexed by the vector value.
  assign w_mismatch = (i_y1 != i_exp_y1[r_abc]) | (i_y2 != i_exp_y2[r_abc]);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode. Abort has priority over a sample that
  // falls on the same edge, so an aborted sweep never records that vector.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = APPLY;
        end
      end
      APPLY: begin
        o_busy = 1'b1;
        if (i_abort) begin
          w_next_state = IDLE;
        end else if (r_cnt == '0) begin
          w_sample = 1'b1;
          if (r_step == 3'd7) begin
            w_next_state = DONE;
          end
        end else begin
          w_count = 1'b1;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Sweep datapath: dwell counter, vector stepping, capture and scoring.
  // The pass flag is computed on the final sample edge with that sample's
  // mismatch folded in, so it is already valid while o_done is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_step      <= '0;
      r_abc       <= '0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_cap_y1    <= '0;
      r_cap_y2    <= '0;
    end else if (w_accept) begin
      r_dwell     <= w_dwell_eff;
      r_cnt       <= w_dwell_eff - DWELL_W'(1);
      r_step      <= '0;
      r_abc       <= step_to_abc(3'd0);
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_cap_y1    <= '0;
      r_cap_y2    <= '0;
    end else if (w_sample) begin
      r_cap_y1[r_abc] <= i_y1;
      r_cap_y2[r_abc] <= i_y2;
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + 4'd1;
        if (r_err_cnt == 4'd0) begin
          r_first_err <= r_abc;
        end
      end
      if (r_step == 3'd7) begin
        r_pass <= (r_err_cnt == 4'd0) && !w_mismatch;
      end else begin
        r_step <= r_step + 3'd1;
        r_abc  <= step_to_abc(r_step + 3'd1);
        r_cnt  <= r_dwell - DWELL_W'(1);
      end
    end else if (w_count) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign o_abc       = r_abc;
  assign o_pass      = r_pass;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_err = r_first_err;
  assign o_cap_y1    = r_cap_y1;
  assign o_cap_y2    = r_cap_y2;

endmodule

// File: tb/tb_logic_vector_sequencer.sv
// tb_logic_vector_sequencer
//
// Purpose: bench for logic_vector_sequencer. A table-driven combinational
// datapath (y = table[abc]) sits on the sequencer outputs. Expected timelines
// and results come from the sweep rules: vector order list, dwell arithmetic
// and truth-table comparison. Honours LOGIC_SEQ_GRAY_EN for the vector order.

module tb_logic_vector_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic       start;
  logic       abort;
  logic [3:0] dwell;
  logic [7:0] expY1;
  logic [7:0] expY2;
  logic [2:0] abc;
  logic       y1;
  logic       y2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] errCnt;
  logic [2:0] firstErr;
  logic [7:0] capY1;
  logic [7:0] capY2;

  // Truth tables of the emulated datapath.
  logic [7:0] dpY1;
  logic [7:0] dpY2;

  logic [2:0] order [0:7];

  int compared = 0;
  int failed   = 0;

  // Per-cycle observations of one sweep, index = cycles after the start edge.
  logic [2:0] recAbc   [0:127];
  logic       recBusy  [0:127];
  logic       recDone  [0:127];
  logic       recPass  [0:127];
  logic [3:0] recErr   [0:127];
  logic [2:0] recFirst [0:127];
  logic [7:0] recCap1  [0:127];
  logic [7:0] recCap2  [0:127];

  assign y1 = dpY1[abc];
  assign y2 = dpY2[abc];

  always #5 clock = ~clock;

  logic_vector_sequencer #(.DWELL_W(4)) dut (
    .i_clk       (clock),
    .i_rst_n     (resetN),
    .i_start     (start),
    .i_abort     (abort),
    .i_dwell     (dwell),
    .i_exp_y1    (expY1),
    .i_exp_y2    (expY2),
    .o_abc       (abc),
    .i_y1        (y1),
    .i_y2        (y2),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_err_cnt   (errCnt),
    .o_first_err (firstErr),
    .o_cap_y1    (capY1),
    .o_cap_y2    (capY2)
  );

  // Starts a sweep at the next edge and records nCycles cycles of outputs,
  // sampled at the falling edge. Optionally asserts abort together with
  // start, and re-pulses start at cycles 2 and 5 while the sweep is running.
  task automatic applyStimulus(input logic [3:0] dw, input bit pulseBusy,
                               input bit abortToo, input int nCycles);
    dwell = dw;
    start = 1'b1;
    abort = abortToo;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= nCycles; c++) begin
      recAbc[c]   = abc;
      recBusy[c]  = busy;
      recDone[c]  = done;
      recPass[c]  = pass;
      recErr[c]   = errCnt;
      recFirst[c] = firstErr;
      recCap1[c]  = capY1;
      recCap2[c]  = capY2;
      start = pulseBusy && (c == 2 || c == 5);
      @(posedge clock);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  // Reference outcome after the first nSamples vectors of the sweep order.
  task automatic modelSweep(input int nSamples, output logic [7:0] mCap1,
                            output logic [7:0] mCap2, output int mErr,
                            output logic [2:0] mFirst);
    logic [2:0] v;
    mCap1  = 8'h00;
    mCap2  = 8'h00;
    mErr   = 0;
    mFirst = 3'd0;
    for (int j = 0; j < nSamples; j++) begin
      v = order[j];
      mCap1[v] = dpY1[v];
      mCap2[v] = dpY2[v];
      if (dpY1[v] != expY1[v] || dpY2[v] != expY2[v]) begin
        if (mErr == 0) mFirst = v;
        mErr++;
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    dwell  = 4'd0;
    dpY1   = 8'h00;
    dpY2   = 8'h00;
    expY1  = 8'h00;
    expY2  = 8'h00;
    #12;
    compared++;
    if ({abc, busy, done, pass} !== 6'b0) begin
      failed++;
      $display("[TB] FAIL reset_ctrl: got abc=%0d busy=%0b done=%0b pass=%0b, want all 0", abc, busy, done, pass);
    end
    compared++;
    if ({errCnt, firstErr, capY1, capY2} !== 23'b0) begin
      failed++;
      $display("[TB] FAIL reset_results: got err=%0d first=%0d cap1=%h cap2=%h, want all 0", errCnt, firstErr, capY1, capY2);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_correct_datapath();
    int d = 3;
    int idx;
    dpY1  = 8'hC0;
    dpY2  = 8'h96;
    expY1 = 8'hC0;
    expY2 = 8'h96;
    applyStimulus(4'd3, 1'b0, 1'b0, 8 * d + 2);
    for (int c = 1; c <= 8 * d + 2; c++) begin
      idx = (c <= 8 * d) ? (c - 1) / d : 7;
      compared++;
      if (recAbc[c] !== order[idx]) begin
        failed++;
        $display("[TB] FAIL correct_abc c=%0d: got %0d want %0d", c, recAbc[c], order[idx]);
      end
      compared++;
      if (recBusy[c] !== (c <= 8 * d) || recDone[c] !== (c == 25)) begin
        failed++;
        $display("[TB] FAIL correct_timing c=%0d: got busy=%0b done=%0b want busy=%0b done=%0b",
                 c, recBusy[c], recDone[c], c <= 8 * d, c == 25);
      end
    end
    compared++;
    if (recPass[25] !== 1'b1 || recErr[25] !== 4'd0) begin
      failed++;
      $display("[TB] FAIL correct_score: got pass=%0b err=%0d want pass=1 err=0", recPass[25], recErr[25]);
    end
    compared++;
    if (recCap1[25] !== 8'hC0 || recCap2[25] !== 8'h96) begin
      failed++;
      $display("[TB] FAIL correct_caps: got %h/%h want c0/96", recCap1[25], recCap2[25]);
    end
  endtask

  task automatic test_stuck_datapath();
    dpY1  = 8'hC0;
    dpY2  = 8'h00;
    expY1 = 8'hC0;
    expY2 = 8'h96;
    applyStimulus(4'd1, 1'b0, 1'b0, 10);
    for (int c = 1; c <= 10; c++) begin
      compared++;
      if (recDone[c] !== (c == 9)) begin
        failed++;
        $display("[TB] FAIL stuck_done c=%0d: got %0b want %0b", c, recDone[c], c == 9);
      end
    end
    compared++;
    if (recPass[9] !== 1'b0 || recErr[9] !== 4'd4 || recFirst[9] !== 3'd1) begin
      failed++;
      $display("[TB] FAIL stuck_score: got pass=%0b err=%0d first=%0d want pass=0 err=4 first=1",
               recPass[9], recErr[9], recFirst[9]);
    end
    compared++;
    if (recCap1[9] !== 8'hC0 || recCap2[9] !== 8'h00) begin
      failed++;
      $display("[TB] FAIL stuck_caps: got %h/%h want c0/00", recCap1[9], recCap2[9]);
    end
  endtask

  task automatic test_dwell0_busy_start();
    int n = 13;
    int idx;
    dpY1  = 8'hC0;
    dpY2  = 8'h96;
    expY1 = 8'hC0;
    expY2 = 8'h96;
    applyStimulus(4'd0, 1'b1, 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      idx = (c <= 8) ? c - 1 : 7;
      compared++;
      if (recAbc[c] !== order[idx] || recBusy[c] !== (c <= 8) || recDone[c] !== (c == 9)) begin
        failed++;
        $display("[TB] FAIL dwell0_timeline c=%0d: got abc=%0d busy=%0b done=%0b want abc=%0d busy=%0b done=%0b",
                 c, recAbc[c], recBusy[c], recDone[c], order[idx], c <= 8, c == 9);
      end
    end
    compared++;
    if (recPass[9] !== 1'b1 || recErr[9] !== 4'd0) begin
      failed++;
      $display("[TB] FAIL dwell0_score: got pass=%0b err=%0d want pass=1 err=0", recPass[9], recErr[9]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] mCap1;
    logic [7:0] mCap2;
    int         mErr;
    logic [2:0] mFirst;
    dpY1  = 8'($urandom);
    dpY2  = 8'($urandom);
    expY1 = 8'($urandom);
    expY2 = 8'($urandom);
    dwell = 4'd2;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    abort = 1'b0;
    modelSweep(2, mCap1, mCap2, mErr, mFirst);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_ctrl: got busy=%0b done=%0b pass=%0b want 0/0/0", busy, done, pass);
    end
    compared++;
    if (abc !== order[2]) begin
      failed++;
      $display("[TB] FAIL abort_abc: got %0d want %0d", abc, order[2]);
    end
    compared++;
    if (errCnt !== 4'(mErr) || capY1 !== mCap1 || capY2 !== mCap2 || (mErr != 0 && firstErr !== mFirst)) begin
      failed++;
      $display("[TB] FAIL abort_partial: got err=%0d first=%0d caps=%h/%h want err=%0d first=%0d caps=%h/%h",
               errCnt, firstErr, capY1, capY2, mErr, mFirst, mCap1, mCap2);
    end
    for (int c = 0; c < 20; c++) begin
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("[TB] FAIL abort_quiet c=%0d: got busy=%0b done=%0b want 0/0", c, busy, done);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset();
    dpY1  = 8'hC0;
    dpY2  = 8'h96;
    expY1 = 8'hC0;
    expY2 = 8'h96;
    dwell = 4'd3;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2;
    resetN = 1'b0;
    #1;
    compared++;
    if ({abc, busy, done, pass} !== 6'b0) begin
      failed++;
      $display("[TB] FAIL async_ctrl: got abc=%0d busy=%0b done=%0b pass=%0b want all 0", abc, busy, done, pass);
    end
    compared++;
    if ({errCnt, firstErr, capY1, capY2} !== 23'b0) begin
      failed++;
      $display("[TB] FAIL async_results: got err=%0d first=%0d caps=%h/%h want all 0", errCnt, firstErr, capY1, capY2);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    applyStimulus(4'd1, 1'b0, 1'b0, 10);
    compared++;
    if (recDone[9] !== 1'b1 || recPass[9] !== 1'b1 || recCap1[9] !== 8'hC0 || recCap2[9] !== 8'h96) begin
      failed++;
      $display("[TB] FAIL async_rerun: got done=%0b pass=%0b caps=%h/%h want 1/1 c0/96",
               recDone[9], recPass[9], recCap1[9], recCap2[9]);
    end
  endtask

  task automatic test_start_abort_idle();
    dpY1  = 8'h5A;
    dpY2  = 8'h3C;
    expY1 = 8'h5A;
    expY2 = 8'h3C;
    applyStimulus(4'd2, 1'b0, 1'b1, 18);
    compared++;
    if (recBusy[1] !== 1'b1 || recDone[17] !== 1'b1 || recPass[17] !== 1'b1) begin
      failed++;
      $display("[TB] FAIL start_abort_idle: got busy1=%0b done17=%0b pass=%0b want 1/1/1",
               recBusy[1], recDone[17], recPass[17]);
    end
  endtask

  task automatic test_random();
    logic [7:0] mCap1;
    logic [7:0] mCap2;
    int         mErr;
    logic [2:0] mFirst;
    logic [3:0] dw;
    int         d;
    int         dc;
    int         idx;
    for (int it = 0; it < 6; it++) begin
      dpY1  = 8'($urandom);
      dpY2  = 8'($urandom);
      expY1 = ($urandom_range(0, 1) == 1) ? dpY1 : 8'($urandom);
      expY2 = ($urandom_range(0, 1) == 1) ? dpY2 : 8'($urandom);
      dw    = 4'($urandom_range(0, 15));
      d     = (dw == 4'd0) ? 1 : int'(dw);
      dc    = 8 * d + 1;
      applyStimulus(dw, 1'b0, 1'b0, dc + 1);
      modelSweep(8, mCap1, mCap2, mErr, mFirst);
      for (int c = 1; c <= dc + 1; c++) begin
        idx = (c <= 8 * d) ? (c - 1) / d : 7;
        compared++;
        if (recAbc[c] !== order[idx] || recBusy[c] !== (c <= 8 * d) || recDone[c] !== (c == dc)) begin
          failed++;
          $display("[TB] FAIL rand_timeline it=%0d c=%0d: got abc=%0d busy=%0b done=%0b want abc=%0d busy=%0b done=%0b",
                   it, c, recAbc[c], recBusy[c], recDone[c], order[idx], c <= 8 * d, c == dc);
        end
      end
      compared++;
      if (recCap1[dc] !== mCap1 || recCap2[dc] !== mCap2) begin
        failed++;
        $display("[TB] FAIL rand_caps it=%0d: got %h/%h want %h/%h", it, recCap1[dc], recCap2[dc], mCap1, mCap2);
      end
      compared++;
      if (recErr[dc] !== 4'(mErr) || recPass[dc] !== (mErr == 0) || (mErr != 0 && recFirst[dc] !== mFirst)) begin
        failed++;
        $display("[TB] FAIL rand_score it=%0d: got err=%0d pass=%0b first=%0d want err=%0d pass=%0b first=%0d",
                 it, recErr[dc], recPass[dc], recFirst[dc], mErr, mErr == 0, mFirst);
      end
    end
  endtask

  // Sequence of scenarios, then the summary line.
  initial begin
`ifdef LOGIC_SEQ_GRAY_EN
    order = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
    order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    $display("[TB] starting logic_vector_sequencer bench");
    test_reset();
    test_correct_datapath();
    test_stuck_datapath();
    test_dwell0_busy_start();
    test_abort();
    test_async_reset();
    test_start_abort_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
